regfile_sweep: RTL
==================

# regfile_sweep

Parametrised multi-read-port register file for the MIPS datapath, replacing the fixed 32×32 two-read-port file. Adds a synchronous active-high reset that drives a hardware clear sweep (one entry per cycle) plus a software clear request, a Busy flag, and write-reject reporting. It sits in the decode stage: read ports feed the ID/EX operands, and the write port is driven from write-back.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable)
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- INIT_VAL, 0, value written to every entry by a clear sweep

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- RegWrite  in  1  write enable
- RegWrAddr  in  ADDR_W  write address
- RegWrData  in  DATA_W  write data
- RegRdAddr  in  N_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- RegRdData  out  N_RD*DATA_W  packed read data, same packing
- ClrReq  in  1  single-cycle request to start a clear sweep
- Busy  out  1  clear sweep in progress
- RegWrReject  out  1  registered pulse: the write attempted in the previous cycle was dropped

## Operation
- FSM has two states: IDLE and CLEAR. A 2-state enum; the sweep counter cnt is ADDR_W bits wide.
- Rst high at an edge: state <= CLEAR, cnt <= 0, RegWrReject <= 0. Array contents are not touched on that edge.
- CLEAR, Rst low: each edge writes INIT_VAL to entry cnt, then cnt <= cnt+1. The edge that writes entry DEPTH-1 sets state <= IDLE and cnt <= 0.
- IDLE with ClrReq=1: state <= CLEAR, cnt <= 0. The entry-0 clear happens on the following edge.
- ClrReq in CLEAR is ignored: the sweep does not restart.
- Rst in CLEAR restarts the sweep at cnt=0.
- Busy = (state == CLEAR), decoded combinationally from the state register.
- Writes:
  - In IDLE, RegWrite=1 writes RegWrData to RegWrAddr at the edge.
  - In CLEAR, the write is dropped, and RegWrReject=1 on the following cycle.
  - With ZERO_REG=1, a write to address 0 is dropped silently (no reject).
- Reads (combinational, each port independent):
  - During CLEAR, every port returns 0.
  - In IDLE, address 0 returns 0 when ZERO_REG=1; otherwise the port returns the array entry.
  - Two ports addressing the same entry return identical data.
- Cleared entry 0 holds INIT_VAL but still reads 0 when ZERO_REG=1.

## Timing
- Reset values: Busy=1 (state CLEAR), RegWrReject=0, RegRdData=0 (forced by CLEAR).
- Clear latency: Rst last high at edge k → Busy low after edge k+DEPTH (32 cycles at defaults). If Rst is held, Busy stays 1 and cnt stays 0.
- ClrReq accepted at edge k → Busy high after edge k, low after edge k+DEPTH.
- Write-to-read latency: the new value is visible on reads in the cycle after the write edge (without bypass).
- RegWrReject is high for exactly one cycle per rejected write; back-to-back rejected writes keep it high.
- ClrReq and RegWrite in the same IDLE cycle: the write commits at that edge, the sweep starts, and the write is overwritten later by the sweep.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In IDLE, a read port whose address equals RegWrAddr with RegWrite=1 returns RegWrData combinationally (same-cycle forwarding).
  - Address 0 is excluded when ZERO_REG=1.
  - No bypass occurs during CLEAR.
- REGFILE_BYPASS_EN undefined: no forwarding; such a read returns the pre-write value.

## Structure
- Shared package regfile_pkg holds:
  - the state enum (IDLE, CLEAR)
  - default width constants DATA_W_DEF=32 and ADDR_W_DEF=5
- Sub-module regfile_clr_seq contains the FSM, cnt, Busy and the RegWrReject register. It outputs clr_we, clr_addr and busy to the array wrapper.
- The array, read muxes and bypass logic stay in regfile_sweep.

## Test plan
- Reset sweep: Rst high 1 cycle, then low → Busy=1 for exactly 32 cycles; all reads are 0 throughout; afterwards every entry reads 0 (INIT_VAL=0).
- Write/read: in IDLE write 0xDEADBEEF to r5 → next cycle all N_RD ports addressing r5 return 0xDEADBEEF. Write 0x1234 to r0 → reads 0, RegWrReject stays 0.
- Reject: ClrReq, then RegWrite to r7 with 0xAA on the 3rd CLEAR cycle → RegWrReject=1 for one cycle; after the sweep r7 reads 0.
- Mid-sweep events: ClrReq at cnt=10 → no restart, Busy falls on schedule. Rst at cnt=10 → Busy stays high for 32 more cycles after Rst drops.
- Bypass: with REGFILE_BYPASS_EN defined, write 0x55 to r3 while port 1 reads r3 → same-cycle 0x55. Without the macro → old value that cycle, 0x55 the next.
- Parameter sweep: ADDR_W=3, DATA_W=16, N_RD=3, ZERO_REG=0, INIT_VAL=0xFFFF → sweep takes 8 cycles; r0 is writable and reads 0xFFFF after the clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default widths for the sweeping register file.
//   state_t    : sequencer state (IDLE, CLEAR)
//   DATA_W_DEF : default register width
//   ADDR_W_DEF : default address width
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: clear-sweep sequencer for regfile_sweep.
// Walks every entry once (one per cycle) after reset or a clear request and
// reports writes that arrive while the sweep owns the array.
// Ports:
//   Clk, Rst       : clock, synchronous active-high reset
//   ClrReq         : single-cycle clear request (honoured only in IDLE)
//   RegWrite       : write attempt from write-back
//   RegWrAddr      : address of that write attempt
//   clr_we         : sweep writes INIT_VAL to clr_addr on this edge
//   clr_addr       : entry currently being cleared
//   busy           : sweep in progress
//   RegWrReject    : registered pulse, previous-cycle write was dropped
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ClrReq,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RegWrAddr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy,
  output logic              RegWrReject
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              wrSilent;

  // Writes to a hardwired-zero entry vanish without being reported.
  assign wrSilent = (ZERO_REG != 0) && (RegWrAddr == '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= CLEAR;
      cnt         <= '0;
      RegWrReject <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          RegWrReject <= 1'b0;
          if (ClrReq) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          RegWrReject <= RegWrite && !wrSilent;
          if (cnt == '1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          RegWrReject <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  // The reset edge itself leaves the array untouched.
  assign clr_we   = busy && !Rst;
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_sweep.sv
// regfile_sweep: parametrised multi-read-port register file with a
// hardware clear sweep, software clear request, Busy and write-reject flag.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding in IDLE.
// Ports:
//   Clk, Rst     : clock, synchronous active-high reset (starts a sweep)
//   RegWrite     : write enable
//   RegWrAddr    : write address
//   RegWrData    : write data
//   RegRdAddr    : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   RegRdData    : packed read data, port i at [i*DATA_W +: DATA_W]
//   ClrReq       : single-cycle request to start a clear sweep
//   Busy         : clear sweep in progress
//   RegWrReject  : registered pulse, previous-cycle write was dropped
module regfile_sweep
  import regfile_pkg::*;
#(
  parameter int              DATA_W   = DATA_W_DEF,
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              N_RD     = 2,
  parameter int              ZERO_REG = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        RegWrAddr,
  input  logic [DATA_W-1:0]        RegWrData,
  input  logic [N_RD*ADDR_W-1:0]   RegRdAddr,
  output logic [N_RD*DATA_W-1:0]   RegRdData,
  input  logic                     ClrReq,
  output logic                     Busy,
  output logic                     RegWrReject
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;
  logic              busy;
  logic              userWe;

  regfile_clr_seq #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) uClrSeq (
    .Clk         (Clk),
    .Rst         (Rst),
    .ClrReq      (ClrReq),
    .RegWrite    (RegWrite),
    .RegWrAddr   (RegWrAddr),
    .clr_we      (clrWe),
    .clr_addr    (clrAddr),
    .busy        (busy),
    .RegWrReject (RegWrReject)
  );

  assign Busy = busy;

  assign userWe = RegWrite && !busy && !Rst &&
                  !((ZERO_REG != 0) && (RegWrAddr == '0));

  // Sweep and user writes are mutually exclusive because userWe needs !busy.
  always_ff @(posedge Clk) begin
    if (clrWe) begin
      mem[clrAddr] <= INIT_VAL;
    end else if (userWe) begin
      mem[RegWrAddr] <= RegWrData;
    end
  end

  always_comb begin
    RegRdData = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      if (!busy &&
          !((ZERO_REG != 0) && (RegRdAddr[i*ADDR_W +: ADDR_W] == '0))) begin
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && (RegRdAddr[i*ADDR_W +: ADDR_W] == RegWrAddr)) begin
          RegRdData[i*DATA_W +: DATA_W] = RegWrData;
        end else begin
          RegRdData[i*DATA_W +: DATA_W] = mem[RegRdAddr[i*ADDR_W +: ADDR_W]];
        end
`else
        RegRdData[i*DATA_W +: DATA_W] = mem[RegRdAddr[i*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

endmodule
